lcd_power_sequencer: RTL and testbench
======================================

# lcd_power_sequencer

- Sequences LVDS LCD panel power-up and power-down around the pixel pipeline.
- Drives, in the panel's required order with timed gaps:
  - panel logic supply enable,
  - LVDS serializer enable (releases serializer reset and clock output),
  - video enable (gates DataEnable and pattern output of the timing generator),
  - backlight enable.
- Runs on the pixel clock, next to the timing generator and 7:1 serializer.
- Forces an orderly shutdown on request or on loss of transmit-MMCM lock.

## Interface
- TICK_DIV, 72000: clk cycles per 1 ms tick (72 MHz pixel clock).
- T_VDD_LVDS, 20: ms from vdd_en rise to lvds_en rise.
- T_LVDS_BL, 200: ms from lvds_en rise to backlight/video on.
- T_BL_LVDS, 200: ms from bl_en fall to lvds_en fall.
- T_LVDS_VDD, 20: ms from lvds_en fall to vdd_en fall.
- T_OFF_MIN, 500: minimum ms with vdd_en low before the next power-up.
- clk  in  1  pixel clock. Only clock.
- rst  in  1  asynchronous, active-low reset.
- enable_req  in  1  level; 1 = panel on requested.
- mmcm_locked  in  1  transmit MMCM lock, synchronous to clk.
- frame_start  in  1  one-cycle pulse at VSync rise from the timing generator.
- vdd_en  out  1  panel logic supply enable.
- lvds_en  out  1  serializer enable.
- video_en  out  1  timing-generator data enable gate.
- bl_en  out  1  backlight enable.
- ready  out  1  1 only in S_ON.
- lock_fault  out  1  sticky; lock was lost while lvds_en=1.
- state  out  3  current state encoding, for debug.

## Operation
- States and outputs (vdd/lvds/video/bl):
  - S_OFF=0: 0000
  - S_PU_VDD=1: 1000
  - S_PU_LVDS=2: 1100
  - S_PU_ALIGN=3: 1100
  - S_ON=4: 1111
  - S_PD_BL=5: 1110
  - S_PD_LVDS=6: 1000
  - S_HOLD=7: 0000
- S_OFF: enable_req && mmcm_locked -> S_PU_VDD. lock_fault is cleared on this transition.
- S_PU_VDD: after T_VDD_LVDS -> S_PU_LVDS. If !enable_req -> S_PD_LVDS.
- S_PU_LVDS: after T_LVDS_BL -> S_PU_ALIGN (macro defined) or S_ON (macro undefined). If !enable_req or !mmcm_locked -> S_PD_LVDS.
- S_PU_ALIGN: frame_start -> S_ON. If !enable_req or !mmcm_locked -> S_PD_LVDS.
- S_ON: if !enable_req or !mmcm_locked -> S_PD_BL.
- S_PD_BL: after T_BL_LVDS -> S_PD_LVDS.
- S_PD_LVDS: after T_LVDS_VDD -> S_HOLD.
- S_HOLD: after T_OFF_MIN -> S_OFF. enable_req is ignored here.
- Lock loss and request drop are checked in the same condition; when both occur together, the result is one transition.
- lock_fault sets on any cycle with lvds_en=1 && !mmcm_locked. It stays set until rst or the next S_OFF->S_PU_VDD transition.
- Power-down states ignore enable_req; the sequence always completes to S_OFF.

## Timing
- All outputs are registered and decoded from the next state, so they change on the same edge as state.
- Condition sampled at edge n -> new state and outputs valid after edge n+1. No other latency.
- Timed states use a prescaler (0..TICK_DIV-1) and a 16-bit ms counter. Both restart on every state entry.
- A timed state with T>=1 lasts exactly T*TICK_DIV cycles. T=0 means exactly 1 cycle.
- Counter widths: prescaler $clog2(TICK_DIV); ms counter 16 bits. Parameters above 65535 are illegal (elaboration assertion).
- During reset assertion and after reset: state=S_OFF; all outputs 0, including lock_fault.
- Reset mid-sequence drops every enable at once. This is accepted; it is a board-level abort.

## Configuration
- LCD_PWRSEQ_FRAME_ALIGN_EN defined:
  - S_PU_ALIGN is used, so bl_en/video_en rise only on the cycle after frame_start.
  - In S_ON, a shutdown request waits for frame_start before entering S_PD_BL. Lock loss is immediate and does not wait.
- Undefined: S_PU_ALIGN is unreachable and frame_start is ignored.

## Structure
- Package lcd_pkg holds:
  - state enum lcd_pwr_state_t, 3 bits, encodings as above;
  - default timing constants LCD_T_VDD_LVDS_MS, LCD_T_LVDS_BL_MS, LCD_T_BL_LVDS_MS, LCD_T_LVDS_VDD_MS, LCD_T_OFF_MIN_MS;
  - LCD_TICK_DIV_72M.
- One sub-module: lcd_ms_timer (prescaler plus ms down-counter).
  - Inputs: load, load value.
  - Output: done pulse.
  - One instance, reloaded on each state entry.

## Test plan
All scenarios use TICK_DIV=4, T_VDD_LVDS=2, T_LVDS_BL=3, T_BL_LVDS=3, T_LVDS_VDD=2, T_OFF_MIN=5.
- Power-up, macro off: enable_req=1, lock=1 -> vdd_en +1 cycle, lvds_en +8 cycles later, bl_en/video_en/ready +12 cycles after that.
- Power-down: from S_ON drop enable_req -> bl_en falls next edge; lvds_en/video_en fall 12 cycles later; vdd_en 8 cycles after that; S_OFF 20 cycles after vdd_en falls.
- Lock loss in S_ON -> S_PD_BL next edge and lock_fault=1. lock_fault stays 1 through S_OFF and clears on the next power-up start.
- Abort in S_PU_VDD at cycle 3 -> S_PD_LVDS with lvds_en never 1; vdd_en low 8 cycles later; enable_req toggles during S_HOLD are ignored.
- Macro on: timer expires in S_PU_LVDS, frame_start arrives 30 cycles later -> bl_en rises exactly 1 cycle after frame_start.
- Reset asserted in S_ON -> all outputs 0 asynchronously; state=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and default timing for the LVDS LCD panel power sequencer.
// Holds the state encoding, the per-state enable pattern and default delays.
// Build option LCD_PWRSEQ_FRAME_ALIGN_EN is consumed by lcd_power_sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PU_VDD   = 3'd1,
    S_PU_LVDS  = 3'd2,
    S_PU_ALIGN = 3'd3,
    S_ON       = 3'd4,
    S_PD_BL    = 3'd5,
    S_PD_LVDS  = 3'd6,
    S_HOLD     = 3'd7
  } lcd_pwr_state_t;

  // Default panel timing in milliseconds, 72 MHz pixel clock.
  localparam int unsigned LCD_TICK_DIV_72M  = 72000;
  localparam int unsigned LCD_T_VDD_LVDS_MS = 20;
  localparam int unsigned LCD_T_LVDS_BL_MS  = 200;
  localparam int unsigned LCD_T_BL_LVDS_MS  = 200;
  localparam int unsigned LCD_T_LVDS_VDD_MS = 20;
  localparam int unsigned LCD_T_OFF_MIN_MS  = 500;
  localparam int unsigned LCD_MS_W          = 16;

  typedef struct packed {
    logic vdd;
    logic lvds;
    logic video;
    logic bl;
  } lcd_pwr_out_t;

  // Enable pattern driven to the panel in each state.
  function automatic lcd_pwr_out_t lcd_decode(input lcd_pwr_state_t s);
    lcd_pwr_out_t o;
    o = '0;
    case (s)
      S_PU_VDD:   o = '{vdd: 1'b1, lvds: 1'b0, video: 1'b0, bl: 1'b0};
      S_PU_LVDS,
      S_PU_ALIGN: o = '{vdd: 1'b1, lvds: 1'b1, video: 1'b0, bl: 1'b0};
      S_ON:       o = '{vdd: 1'b1, lvds: 1'b1, video: 1'b1, bl: 1'b1};
      S_PD_BL:    o = '{vdd: 1'b1, lvds: 1'b1, video: 1'b1, bl: 1'b0};
      S_PD_LVDS:  o = '{vdd: 1'b1, lvds: 1'b0, video: 1'b0, bl: 1'b0};
      default:    o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lcd_ms_timer.sv
// Millisecond timer: prescaler of TICK_DIV clocks feeding a 16-bit ms down-counter.
// done_o is combinational in the last cycle of the loaded interval (load 0 -> first cycle).
// No backpressure; load_i restarts both counters on the next edge.
module lcd_ms_timer
  import lcd_pkg::*;
#(
  parameter int unsigned TICK_DIV = LCD_TICK_DIV_72M
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [LCD_MS_W-1:0] ms_i,
  output logic                done_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("lcd_ms_timer: TICK_DIV must be at least 1");
  end

  logic [PW-1:0]       pre_q, pre_d;
  logic [LCD_MS_W-1:0] ms_q, ms_d;
  logic                tick;

  assign tick   = (pre_q == PRE_LAST);
  // Loaded N ms: the Nth tick boundary lands on the last cycle of the interval.
  assign done_o = (ms_q == '0) || ((ms_q == LCD_MS_W'(1)) && tick);

  // Prescaler wraps every TICK_DIV cycles; ms counter steps down on wrap and holds at 0.
  always_comb begin
    pre_d = pre_q;
    ms_d  = ms_q;
    if (load_i) begin
      pre_d = '0;
      ms_d  = ms_i;
    end else begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick && (ms_q != '0)) ms_d = ms_q - LCD_MS_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

endmodule

// File: rtl/lcd_power_sequencer.sv
// LVDS LCD power sequencer: vdd -> lvds -> video/backlight up, reverse order down.
// Outputs registered from next state (one edge after the sampled condition).
// Option LCD_PWRSEQ_FRAME_ALIGN_EN: align backlight-on and request-off to frame_start.
module lcd_power_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned TICK_DIV   = LCD_TICK_DIV_72M,
  parameter int unsigned T_VDD_LVDS = LCD_T_VDD_LVDS_MS,
  parameter int unsigned T_LVDS_BL  = LCD_T_LVDS_BL_MS,
  parameter int unsigned T_BL_LVDS  = LCD_T_BL_LVDS_MS,
  parameter int unsigned T_LVDS_VDD = LCD_T_LVDS_VDD_MS,
  parameter int unsigned T_OFF_MIN  = LCD_T_OFF_MIN_MS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_req,
  input  logic       mmcm_locked,
  input  logic       frame_start,
  output logic       vdd_en,
  output logic       lvds_en,
  output logic       video_en,
  output logic       bl_en,
  output logic       ready,
  output logic       lock_fault,
  output logic [2:0] state
);

  if ((T_VDD_LVDS > 65535) || (T_LVDS_BL > 65535) || (T_BL_LVDS > 65535) ||
      (T_LVDS_VDD > 65535) || (T_OFF_MIN > 65535)) begin : g_bad_time
    $error("lcd_power_sequencer: ms delays must fit in 16 bits");
  end

  lcd_pwr_state_t      state_q, state_d;
  lcd_pwr_out_t        out_q, out_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;
  logic                tmr_load, tmr_done;
  logic [LCD_MS_W-1:0] tmr_ms;
  logic                abort;

  assign abort = !enable_req || !mmcm_locked;

  // Timer restarts with the delay of whichever state is being entered.
  assign tmr_load = (state_d != state_q);
  always_comb begin
    tmr_ms = '0;
    case (state_d)
      S_PU_VDD:  tmr_ms = LCD_MS_W'(T_VDD_LVDS);
      S_PU_LVDS: tmr_ms = LCD_MS_W'(T_LVDS_BL);
      S_PD_BL:   tmr_ms = LCD_MS_W'(T_BL_LVDS);
      S_PD_LVDS: tmr_ms = LCD_MS_W'(T_LVDS_VDD);
      S_HOLD:    tmr_ms = LCD_MS_W'(T_OFF_MIN);
      default:   tmr_ms = '0;
    endcase
  end

  lcd_ms_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (tmr_load),
    .ms_i   (tmr_ms),
    .done_o (tmr_done)
  );

  // State, enables, ready and sticky lock fault; reset drops everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_OFF;
      out_q   <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  // Next-state: timed advance on power-up, abort to the matching power-down step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:      if (enable_req && mmcm_locked) state_d = S_PU_VDD;
      S_PU_VDD:   if (!enable_req) state_d = S_PD_LVDS;
                  else if (tmr_done) state_d = S_PU_LVDS;
`ifdef LCD_PWRSEQ_FRAME_ALIGN_EN
      S_PU_LVDS:  if (abort) state_d = S_PD_LVDS;
                  else if (tmr_done) state_d = S_PU_ALIGN;
      S_PU_ALIGN: if (abort) state_d = S_PD_LVDS;
                  else if (frame_start) state_d = S_ON;
      // Lock loss is urgent; a plain off request waits for a frame boundary.
      S_ON:       if (!mmcm_locked || (!enable_req && frame_start)) state_d = S_PD_BL;
`else
      S_PU_LVDS:  if (abort) state_d = S_PD_LVDS;
                  else if (tmr_done) state_d = S_ON;
      S_PU_ALIGN: state_d = S_PD_LVDS;
      S_ON:       if (abort) state_d = S_PD_BL;
`endif
      S_PD_BL:    if (tmr_done) state_d = S_PD_LVDS;
      S_PD_LVDS:  if (tmr_done) state_d = S_HOLD;
      S_HOLD:     if (tmr_done) state_d = S_OFF;
      default:    state_d = S_OFF;
    endcase
  end

  // Outputs decoded from the next state so they move on the same edge as state.
  always_comb begin
    out_d   = lcd_decode(state_d);
    ready_d = (state_d == S_ON);
    if ((state_q == S_OFF) && (state_d == S_PU_VDD)) fault_d = 1'b0;
    else fault_d = fault_q || (out_q.lvds && !mmcm_locked);
  end

`ifndef LCD_PWRSEQ_FRAME_ALIGN_EN
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  assign vdd_en     = out_q.vdd;
  assign lvds_en    = out_q.lvds;
  assign video_en   = out_q.video;
  assign bl_en      = out_q.bl;
  assign ready      = ready_q;
  assign lock_fault = fault_q;
  assign state      = state_q;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Directed bench for lcd_power_sequencer with short timing (4 clk/ms).
// Observed word: {vdd,lvds,video,bl,ready,lock_fault,state[2:0]}.
module tb_lcd_power_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable_req = 1'b0;
  logic       mmcm_locked = 1'b1;
  logic       frame_start = 1'b0;
  logic       vdd_en, lvds_en, video_en, bl_en, ready, lock_fault;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  lcd_power_sequencer #(
    .TICK_DIV(4), .T_VDD_LVDS(2), .T_LVDS_BL(3),
    .T_BL_LVDS(3), .T_LVDS_VDD(2), .T_OFF_MIN(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_req  (enable_req),
    .mmcm_locked (mmcm_locked),
    .frame_start (frame_start),
    .vdd_en      (vdd_en),
    .lvds_en     (lvds_en),
    .video_en    (video_en),
    .bl_en       (bl_en),
    .ready       (ready),
    .lock_fault  (lock_fault),
    .state       (state)
  );

  always #5 clk = ~clk;

  logic [8:0] obs;
  assign obs = {vdd_en, lvds_en, video_en, bl_en, ready, lock_fault, state};

  // Advance n rising edges, then sit 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  initial begin
    // Reset held: everything low.
    #2;
    check("reset_hold", 9'b0000_0_0_000);
    step(2);
    check("reset_hold_clk", 9'b0000_0_0_000);
    #2 rst = 1'b1;
    step(2);
    check("idle_off", 9'b0000_0_0_000);

    // Power-up: vdd next edge, lvds 8 cycles later, video/bl 12 after that.
    enable_req = 1'b1;
    step(1);  check("pu_vdd_enter", 9'b1000_0_0_001);
    step(7);  check("pu_vdd_last",  9'b1000_0_0_001);
    step(1);  check("pu_lvds_enter", 9'b1100_0_0_010);
    step(11); check("pu_lvds_last", 9'b1100_0_0_010);
    step(1);  check("on_enter", 9'b1111_1_0_100);

    // Power-down by request.
    enable_req = 1'b0;
    step(1);  check("pd_bl_enter", 9'b1110_0_0_101);
    step(11); check("pd_bl_last", 9'b1110_0_0_101);
    step(1);  check("pd_lvds_enter", 9'b1000_0_0_110);
    step(7);  check("pd_lvds_last", 9'b1000_0_0_110);
    step(1);  check("hold_enter", 9'b0000_0_0_111);
    step(19); check("hold_last", 9'b0000_0_0_111);
    step(1);  check("off_after_hold", 9'b0000_0_0_000);

    // Lock loss in S_ON: immediate power-down, sticky fault.
    enable_req = 1'b1;
    step(21); check("on_again", 9'b1111_1_0_100);
    mmcm_locked = 1'b0;
    step(1);  check("lock_loss_pd_bl", 9'b1110_0_1_101);
    mmcm_locked = 1'b1;
    enable_req  = 1'b0;
    step(12); check("lock_pd_lvds", 9'b1000_0_1_110);
    step(28); check("fault_sticky_off", 9'b0000_0_1_000);
    enable_req = 1'b1;
    step(1);  check("fault_clear_pu", 9'b1000_0_0_001);

    // Abort during S_PU_VDD: skip to S_PD_LVDS with lvds never raised.
    step(2);
    enable_req = 1'b0;
    step(1);  check("abort_pd_lvds", 9'b1000_0_0_110);
    step(7);  check("abort_pd_lvds_last", 9'b1000_0_0_110);
    step(1);  check("abort_hold", 9'b0000_0_0_111);
    enable_req = 1'b1; step(3);
    enable_req = 1'b0; step(3);
    enable_req = 1'b1; step(3);
    check("hold_ignores_req", 9'b0000_0_0_111);
    enable_req = 1'b0;
    step(10); check("abort_hold_last", 9'b0000_0_0_111);
    step(1);  check("abort_off", 9'b0000_0_0_000);

    // Power up again to the post-timer state.
    enable_req = 1'b1;
    step(21);
`ifdef LCD_PWRSEQ_FRAME_ALIGN_EN
    check("align_enter", 9'b1100_0_0_011);
    step(29); check("align_wait", 9'b1100_0_0_011);
    frame_start = 1'b1;
    step(1);  check("align_on", 9'b1111_1_0_100);
    frame_start = 1'b0;
    enable_req  = 1'b0;
    step(3);  check("on_waits_frame", 9'b1111_1_0_100);
    enable_req  = 1'b1;
    step(1);
`else
    check("on_third", 9'b1111_1_0_100);
    frame_start = 1'b1;
    step(1);  check("frame_start_ignored", 9'b1111_1_0_100);
    frame_start = 1'b0;
`endif

    // Asynchronous reset in S_ON drops everything without a clock edge.
    #2 rst = 1'b0;
    #1 check("async_reset", 9'b0000_0_0_000);
    step(2);  check("reset_held_on", 9'b0000_0_0_000);
    enable_req = 1'b0;
    #2 rst = 1'b1;
    step(3);  check("post_reset_off", 9'b0000_0_0_000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
